// File: rtl/ahb_apb_bridge_ctrl_if.sv
// ----------------------------------------------------------------------------
// ahb_apb_bridge_ctrl_if
//
// Purpose:
//   Bundles the AHB-slave side and the APB-master side signals of the
//   AHB-to-APB bridge controller into one interface.
//
// Signals:
//   AHB : Hwrite, Hreadyin, Htrans[1:0], Haddr, Hwdata  (toward the bridge)
//         Hreadyout, Hresp[1:0], Hrdata                 (from the bridge)
//   APB : Paddr, Pwdata, Pwrite, Pselx[NSLV], Penable   (from the bridge)
//         Prdata, Pready, Pslverr                       (toward the bridge)
//
// Modports:
//   slave  - the bridge controller's view (AHB slave / APB master).
//   master - the environment's view (AHB master plus the APB slaves).
// ----------------------------------------------------------------------------
interface ahb_apb_bridge_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 4
);
    // AHB side
    logic              Hwrite;
    logic              Hreadyin;
    logic [1:0]        Htrans;
    logic [ADDR_W-1:0] Haddr;
    logic [DATA_W-1:0] Hwdata;
    logic              Hreadyout;
    logic [1:0]        Hresp;
    logic [DATA_W-1:0] Hrdata;

    // APB side
    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;
    logic              Pwrite;
    logic [NSLV-1:0]   Pselx;
    logic              Penable;
    logic [DATA_W-1:0] Prdata;
    logic              Pready;
    logic              Pslverr;

    modport slave (
        input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata,
        input  Prdata, Pready, Pslverr,
        output Hreadyout, Hresp, Hrdata,
        output Paddr, Pwdata, Pwrite, Pselx, Penable
    );

    modport master (
        output Hwrite, Hreadyin, Htrans, Haddr, Hwdata,
        output Prdata, Pready, Pslverr,
        input  Hreadyout, Hresp, Hrdata,
        input  Paddr, Pwdata, Pwrite, Pselx, Penable
    );
endinterface

// File: rtl/ahb_apb_bridge_ctrl.sv
// ----------------------------------------------------------------------------
// ahb_apb_bridge_ctrl
//
// Purpose:
//   Core controller of the AHB-to-APB bridge. Every accepted AHB beat
//   (NONSEQ or SEQ) is turned into one APB SETUP/ENABLE access. Hreadyout is
//   held low while the APB access is in flight; read data or a two-cycle
//   ERROR response is returned on the AHB side. Addresses outside the
//   decoded APB window get an ERROR response without touching APB.
//
// Ports:
//   clk      - bridge clock, all state updated on the rising edge
//   Hresetn  - asynchronous, active-low reset
//   bus      - ahb_apb_bridge_ctrl_if.slave
//              AHB in : Hwrite, Hreadyin, Htrans, Haddr, Hwdata
//              AHB out: Hreadyout, Hresp, Hrdata
//              APB out: Paddr, Pwdata, Pwrite, Pselx (one-hot), Penable
//              APB in : Prdata, Pready, Pslverr
//
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module ahb_apb_bridge_ctrl #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                NSLV       = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                SLOT_SHIFT = 26
) (
    input  logic                  clk,
    input  logic                  Hresetn,
    ahb_apb_bridge_ctrl_if.slave  bus
);

    localparam int SLOT_W = (NSLV > 1) ? $clog2(NSLV) : 1;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        WWAIT,
        SETUP,
        ENABLE,
        ERR1,
        ERR2
    } state_t;

    state_t              state;

    logic                hready_q;
    logic [1:0]          hresp_q;
    logic [DATA_W-1:0]   hrdata_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic                pwrite_q;
    logic [NSLV-1:0]     psel_q;
    logic                penable_q;

    // Address-phase information captured when a beat is accepted.
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [SLOT_W-1:0]   slot_q;

    logic [ADDR_W-1:0]   addr_offset;
    logic [ADDR_W-1:0]   slot_full;
    logic [SLOT_W-1:0]   slot_dec;
    logic                in_range;
    logic                valid_xfer;

    function automatic logic [NSLV-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
        return NSLV'(1) << s;
    endfunction

    // Address decode. The full-width slot index is compared against NSLV so
    // that addresses far above the last slave (and the wrap-around produced
    // by addresses below BASE_ADDR) are rejected rather than aliased.
    assign addr_offset = bus.Haddr - BASE_ADDR;
    assign slot_full   = addr_offset >> SLOT_SHIFT;
    assign slot_dec    = slot_full[SLOT_W-1:0];
    assign in_range    = (bus.Haddr >= BASE_ADDR) && (slot_full < ADDR_W'(NSLV));

    // Only NONSEQ/SEQ beats count; IDLE/BUSY are answered OKAY with no
    // wait state simply by not being accepted.
    assign valid_xfer  = bus.Hreadyin && hready_q && bus.Htrans[1];

    // Controller state machine. Every output register is assigned on the
    // transition into the state in which it must be visible, so the APB
    // phases and the AHB response appear exactly in the cycle of their state.
    always_ff @(posedge clk or negedge Hresetn) begin
        if (!Hresetn) begin
            state     <= IDLE;
            hready_q  <= 1'b1;
            hresp_q   <= RESP_OKAY;
            hrdata_q  <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            slot_q    <= '0;
        end else begin
            case (state)
                // ERR2 is the second ERROR cycle; Hreadyout is already high
                // there, so the next address is sampled exactly as in IDLE.
                IDLE, ERR2: begin
                    hready_q <= 1'b1;
                    hresp_q  <= RESP_OKAY;
                    state    <= IDLE;
                    if (valid_xfer) begin
                        addr_q   <= bus.Haddr;
                        write_q  <= bus.Hwrite;
                        slot_q   <= slot_dec;
                        hready_q <= 1'b0;
                        if (!in_range) begin
                            hresp_q <= RESP_ERROR;
                            state   <= ERR1;
                        end else if (bus.Hwrite) begin
                            state <= WWAIT;
                        end else begin
                            psel_q   <= slot_onehot(slot_dec);
                            paddr_q  <= bus.Haddr;
                            pwrite_q <= 1'b0;
                            state    <= SETUP;
                        end
                    end
                end

                // Write data is only valid in the AHB data phase, one cycle
                // after the address was accepted.
                WWAIT: begin
                    pwdata_q <= bus.Hwdata;
                    psel_q   <= slot_onehot(slot_q);
                    paddr_q  <= addr_q;
                    pwrite_q <= 1'b1;
                    state    <= SETUP;
                end

                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ENABLE;
                end

                ENABLE: begin
                    if (bus.Pready) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        if (bus.Pslverr) begin
                            hresp_q <= RESP_ERROR;
                            state   <= ERR1;
                        end else begin
                            hready_q <= 1'b1;
                            hresp_q  <= RESP_OKAY;
                            if (!write_q) begin
                                hrdata_q <= bus.Prdata;
                            end
                            state <= IDLE;
                        end
                    end
                end

                ERR1: begin
                    hready_q <= 1'b1;
                    state    <= ERR2;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Hreadyout = hready_q;
    assign bus.Hresp     = hresp_q;
    assign bus.Hrdata    = hrdata_q;
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;
    assign bus.Pwrite    = pwrite_q;
    assign bus.Pselx     = psel_q;
    assign bus.Penable   = penable_q;

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ahb_apb_bridge_ctrl
//
// Purpose:
//   Self-checking bench for ahb_apb_bridge_ctrl. An AHB master thread issues
//   beats; an APB slave model answers them with a programmable number of wait
//   states, read data and slave error. Expected AHB responses and expected
//   APB accesses are queued when a beat is driven and are popped and compared
//   when the controller produces them.
// ----------------------------------------------------------------------------
module tb_ahb_apb_bridge_ctrl;

    logic clk;
    logic Hresetn;

    ahb_apb_bridge_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NSLV(4)) bus();

    ahb_apb_bridge_ctrl #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .NSLV      (4),
        .BASE_ADDR (32'h8000_0000),
        .SLOT_SHIFT(26)
    ) dut (
        .clk     (clk),
        .Hresetn (Hresetn),
        .bus     (bus.slave)
    );

    typedef struct {
        logic        is_err;
        logic [31:0] rdata;
        int          exp_low;
    } resp_t;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          waits;
        logic        slverr;
        logic [31:0] rdata;
    } apb_item_t;

    resp_t       resp_q[$];
    apb_item_t   apb_q[$];

    int          checks;
    int          failures;
    logic [31:0] exp_hrdata;

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one AHB beat at a falling edge once the bridge is ready, queue
    // its expected APB access and AHB response, then move to the data phase.
    // Expected Hreadyout-low cycles follow the bridge latency: read 2, write
    // 3, plus one per APB wait state, plus one for a slave error; an
    // out-of-range beat is low only for the first ERROR cycle.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] sel, input int waits, input logic slverr,
                                 input logic [31:0] rdata, input logic abort);
        resp_t     r;
        apb_item_t a;
        int        guard;
        guard = 0;
        while (!bus.Hreadyout && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("hready_before_drive", 64'(bus.Hreadyout), 64'(1));
        bus.Haddr    = addr;
        bus.Hwrite   = wr;
        bus.Htrans   = 2'b10;
        bus.Hreadyin = 1'b1;
        if (sel != 4'b0000) begin
            a.sel    = sel;
            a.addr   = addr;
            a.wr     = wr;
            a.wdata  = wdata;
            a.waits  = waits;
            a.slverr = slverr;
            a.rdata  = rdata;
            apb_q.push_back(a);
        end
        if (!abort) begin
            if (sel != 4'b0000 && !wr && !slverr) begin
                exp_hrdata = rdata;
            end
            r.is_err  = (sel == 4'b0000) || slverr;
            r.rdata   = exp_hrdata;
            r.exp_low = (sel == 4'b0000) ? 1 : ((wr ? 3 : 2) + waits + (slverr ? 1 : 0));
            resp_q.push_back(r);
        end
        @(negedge clk);
        bus.Htrans = 2'b00;
        bus.Hwdata = wdata;
    endtask

    // APB slave model and APB-side checker.
    initial begin : apb_model
        apb_item_t cur;
        int        waits_left;
        int        en_cnt;
        logic      in_acc;
        logic      prev_setup;
        in_acc      = 1'b0;
        prev_setup  = 1'b0;
        waits_left  = 0;
        en_cnt      = 0;
        bus.Pready  = 1'b0;
        bus.Pslverr = 1'b0;
        bus.Prdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (!Hresetn) begin
                in_acc      = 1'b0;
                prev_setup  = 1'b0;
                bus.Pready  = 1'b0;
                bus.Pslverr = 1'b0;
            end else begin
                if (prev_setup) begin
                    checkOutput("apb_setup_one_cycle", 64'(bus.Penable), 64'(1));
                end
                prev_setup = 1'b0;
                if (bus.Pselx != 4'b0000 && !bus.Penable) begin
                    checkOutput("apb_access_expected", 64'(apb_q.size() > 0), 64'(1));
                    if (apb_q.size() > 0) begin
                        cur        = apb_q.pop_front();
                        in_acc     = 1'b1;
                        en_cnt     = 0;
                        waits_left = cur.waits;
                        prev_setup = 1'b1;
                        checkOutput("setup_pselx", 64'(bus.Pselx), 64'(cur.sel));
                        checkOutput("setup_paddr", 64'(bus.Paddr), 64'(cur.addr));
                        checkOutput("setup_pwrite", 64'(bus.Pwrite), 64'(cur.wr));
                        if (cur.wr) begin
                            checkOutput("setup_pwdata", 64'(bus.Pwdata), 64'(cur.wdata));
                        end
                    end
                end else if (bus.Penable && in_acc) begin
                    en_cnt++;
                    checkOutput("enable_pselx", 64'(bus.Pselx), 64'(cur.sel));
                    checkOutput("enable_paddr", 64'(bus.Paddr), 64'(cur.addr));
                    checkOutput("enable_pwrite", 64'(bus.Pwrite), 64'(cur.wr));
                    if (cur.wr) begin
                        checkOutput("enable_pwdata", 64'(bus.Pwdata), 64'(cur.wdata));
                    end
                end else if (in_acc) begin
                    checkOutput("apb_enable_cycles", 64'(en_cnt), 64'(cur.waits + 1));
                    checkOutput("apb_pselx_released", 64'(bus.Pselx), 64'(0));
                    checkOutput("apb_paddr_held", 64'(bus.Paddr), 64'(cur.addr));
                    in_acc = 1'b0;
                end
                if (bus.Penable && in_acc) begin
                    if (waits_left > 0) begin
                        waits_left--;
                        bus.Pready  = 1'b0;
                        bus.Pslverr = 1'b0;
                        bus.Prdata  = 32'hBAD0_BAD0;
                    end else begin
                        bus.Pready  = 1'b1;
                        bus.Pslverr = cur.slverr;
                        bus.Prdata  = cur.wr ? 32'hBAD1_BAD1 : cur.rdata;
                    end
                end else begin
                    bus.Pready  = 1'b0;
                    bus.Pslverr = 1'b0;
                    bus.Prdata  = 32'hBAD2_BAD2;
                end
            end
        end
    end

    // AHB response monitor: pops the scoreboard on each OKAY completion
    // (Hreadyout rising with OKAY) or on the first ERROR cycle.
    initial begin : resp_monitor
        resp_t r;
        int    low_cnt;
        int    err_phase;
        logic  prev_ready;
        low_cnt    = 0;
        err_phase  = 0;
        prev_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!Hresetn) begin
                low_cnt    = 0;
                err_phase  = 0;
                prev_ready = 1'b1;
            end else begin
                if (!bus.Hreadyout) begin
                    low_cnt++;
                end
                if (err_phase == 1) begin
                    checkOutput("err2_hreadyout", 64'(bus.Hreadyout), 64'(1));
                    checkOutput("err2_hresp", 64'(bus.Hresp), 64'(2'b01));
                    low_cnt   = 0;
                    err_phase = 2;
                end else if (err_phase == 2) begin
                    checkOutput("after_err2_hresp", 64'(bus.Hresp), 64'(2'b00));
                    err_phase = 0;
                end else if (!bus.Hreadyout && bus.Hresp == 2'b01) begin
                    checkOutput("resp_expected", 64'(resp_q.size() > 0), 64'(1));
                    if (resp_q.size() > 0) begin
                        r = resp_q.pop_front();
                        checkOutput("err1_hresp", 64'(bus.Hresp), 64'(r.is_err ? 2'b01 : 2'b00));
                        checkOutput("err1_low_cycles", 64'(low_cnt), 64'(r.exp_low));
                        checkOutput("err1_hrdata_held", 64'(bus.Hrdata), 64'(r.rdata));
                    end
                    err_phase = 1;
                end else if (bus.Hreadyout && !prev_ready) begin
                    checkOutput("resp_expected", 64'(resp_q.size() > 0), 64'(1));
                    if (resp_q.size() > 0) begin
                        r = resp_q.pop_front();
                        checkOutput("done_hresp", 64'(bus.Hresp), 64'(r.is_err ? 2'b01 : 2'b00));
                        checkOutput("done_low_cycles", 64'(low_cnt), 64'(r.exp_low));
                        checkOutput("done_hrdata", 64'(bus.Hrdata), 64'(r.rdata));
                    end
                    low_cnt = 0;
                end
                prev_ready = bus.Hreadyout;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin : main
        logic [31:0] bnd_addr [6];
        logic [3:0]  bnd_sel  [6];
        int          guard;
        checks     = 0;
        failures   = 0;
        exp_hrdata = 32'h0;

        bus.Hwrite   = 1'b0;
        bus.Hreadyin = 1'b1;
        bus.Htrans   = 2'b00;
        bus.Haddr    = 32'h0;
        bus.Hwdata   = 32'h0;
        Hresetn      = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_hreadyout", 64'(bus.Hreadyout), 64'(1));
        checkOutput("rst_pselx", 64'(bus.Pselx), 64'(0));
        checkOutput("rst_paddr", 64'(bus.Paddr), 64'(0));
        checkOutput("rst_pwdata", 64'(bus.Pwdata), 64'(0));
        Hresetn = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_hreadyout", 64'(bus.Hreadyout), 64'(1));
        checkOutput("post_rst_hresp", 64'(bus.Hresp), 64'(2'b00));
        checkOutput("post_rst_pselx", 64'(bus.Pselx), 64'(0));
        checkOutput("post_rst_penable", 64'(bus.Penable), 64'(0));
        checkOutput("post_rst_pwrite", 64'(bus.Pwrite), 64'(0));
        checkOutput("post_rst_hrdata", 64'(bus.Hrdata), 64'(0));

        // Basic write, wait-stated read, out-of-range read.
        applyStimulus(1'b1, 32'h8400_0010, 32'hDEAD_BEEF, 4'b0010, 0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h8C00_0004, 32'h0, 4'b1000, 2, 1'b0, 32'h1234_5678, 1'b0);
        applyStimulus(1'b0, 32'h9000_0000, 32'h0, 4'b0000, 0, 1'b0, 32'h0, 1'b0);

        // Slave error on a write, then a read accepted during ERR2.
        applyStimulus(1'b1, 32'h8000_0000, 32'hCAFE_0001, 4'b0001, 0, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h8800_0000, 32'h0, 4'b0100, 0, 1'b0, 32'hA5A5_0F0F, 1'b0);

        // Hreadyin low with NONSEQ, then BUSY: nothing may start.
        guard = 0;
        while ((resp_q.size() != 0 || !bus.Hreadyout) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("idle_reached", 64'(bus.Hreadyout), 64'(1));
        bus.Haddr    = 32'h8000_0100;
        bus.Hwrite   = 1'b0;
        bus.Htrans   = 2'b10;
        bus.Hreadyin = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("hreadyin_low_hreadyout", 64'(bus.Hreadyout), 64'(1));
            checkOutput("hreadyin_low_pselx", 64'(bus.Pselx), 64'(0));
        end
        bus.Htrans   = 2'b01;
        bus.Hreadyin = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("busy_hreadyout", 64'(bus.Hreadyout), 64'(1));
            checkOutput("busy_hresp", 64'(bus.Hresp), 64'(2'b00));
            checkOutput("busy_pselx", 64'(bus.Pselx), 64'(0));
        end
        bus.Htrans = 2'b00;
        @(negedge clk);

        // Back-to-back in-range beats with random slot, direction and waits.
        for (int i = 0; i < 8; i++) begin
            int unsigned slot;
            logic [31:0] addr;
            slot = $urandom_range(0, 3);
            addr = 32'h8000_0000 + (32'(slot) << 26) + ($urandom & 32'h03FF_FFFC);
            applyStimulus(1'($urandom_range(0, 1)), addr, $urandom, 4'(4'b0001 << slot),
                          int'($urandom_range(0, 2)), 1'b0, $urandom, 1'b0);
        end

        // Decode boundaries; out-of-range entries never adjacent.
        bnd_addr[0] = 32'h7FFF_FFFC; bnd_sel[0] = 4'b0000;
        bnd_addr[1] = 32'h83FF_FFFF; bnd_sel[1] = 4'b0001;
        bnd_addr[2] = 32'h9000_0000; bnd_sel[2] = 4'b0000;
        bnd_addr[3] = 32'h8400_0000; bnd_sel[3] = 4'b0010;
        bnd_addr[4] = 32'hFFFF_FFFC; bnd_sel[4] = 4'b0000;
        bnd_addr[5] = 32'h8FFF_FFFC; bnd_sel[5] = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, bnd_addr[i], 32'h0, bnd_sel[i], i % 2, 1'b0,
                          32'h5000_0000 + 32'(i), 1'b0);
        end

        // Reset asserted in the middle of an ENABLE phase.
        applyStimulus(1'b0, 32'h8000_0008, 32'h0, 4'b0001, 6, 1'b0, 32'h7777_7777, 1'b1);
        guard = 0;
        while (!bus.Penable && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("enable_before_reset", 64'(bus.Penable), 64'(1));
        #2;
        Hresetn = 1'b0;
        #1;
        checkOutput("async_rst_pselx", 64'(bus.Pselx), 64'(0));
        checkOutput("async_rst_penable", 64'(bus.Penable), 64'(0));
        checkOutput("async_rst_hreadyout", 64'(bus.Hreadyout), 64'(1));
        repeat (2) @(negedge clk);
        Hresetn    = 1'b1;
        exp_hrdata = 32'h0;
        @(negedge clk);
        checkOutput("abort_hreadyout", 64'(bus.Hreadyout), 64'(1));
        checkOutput("abort_hresp", 64'(bus.Hresp), 64'(2'b00));
        checkOutput("abort_hrdata", 64'(bus.Hrdata), 64'(0));
        checkOutput("abort_pselx", 64'(bus.Pselx), 64'(0));
        repeat (3) @(negedge clk);

        checkOutput("resp_queue_drained", 64'(resp_q.size()), 64'(0));
        checkOutput("apb_queue_drained", 64'(apb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
